// File: rtl/ex_divider_pkg.sv
// rtl/ex_divider_pkg.sv - shared encodings for the EX-stage divide unit
//
// Purpose: operation and FSM state encodings plus the default operand width
//          used by ex_divider and div_step.
// Contents: XLEN_DEFAULT, divOp_t (DIV_OP_*), divState_t (DIV_*).
package ex_divider_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } divOp_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } divState_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Purpose: shift {rem, quo} left by one and trial-subtract the divisor;
//          keep the difference and set the quotient LSB when it is non-negative.
// Ports:
//   rem      in  XLEN+1 : partial remainder
//   quo      in  XLEN   : partial quotient / remaining dividend bits
//   divisor  in  XLEN   : divisor magnitude
//   remNext  out XLEN+1 : updated partial remainder
//   quoNext  out XLEN   : updated partial quotient
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   remNext,
  output logic [XLEN-1:0] quoNext
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            nonNeg;

  // One extra bit above the shifted remainder carries the trial borrow.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor};
  assign nonNeg  = ~diff[XLEN+1];

  assign remNext = nonNeg ? diff[XLEN:0] : shifted[XLEN:0];
  assign quoNext = {quo[XLEN-2:0], nonNeg};

endmodule

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - iterative RV32M divide/remainder unit for the EX stage
//
// Purpose: 32-step restoring DIV/DIVU/REM/REMU with front-end stall request,
//          flush handling and result hold under downstream stalls.
// Ports:
//   clk, rst_n     in        : clock, asynchronous active-low reset
//   EX_DivValid    in  1     : divide-class instruction in EX
//   EX_DivOp       in  2     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   EX_Rs1Data     in  XLEN  : dividend
//   EX_Rs2Data     in  XLEN  : divisor
//   EX_Flush       in  1     : EX instruction cancelled
//   EX_Hold        in  1     : downstream stall freezing EX
//   EX_StallReq    out 1     : front-end stall request
//   Div_Done       out 1     : Div_Result valid this cycle
//   Div_Result     out XLEN  : quotient or remainder
module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_DivValid,
  input  logic [1:0]      EX_DivOp,
  input  logic [XLEN-1:0] EX_Rs1Data,
  input  logic [XLEN-1:0] EX_Rs2Data,
  input  logic            EX_Flush,
  input  logic            EX_Hold,
  output logic            EX_StallReq,
  output logic            Div_Done,
  output logic [XLEN-1:0] Div_Result
);

  localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN-1);

  divState_t state, stateNext;

  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    remReg;
  logic [XLEN-1:0]  quoReg;
  logic [XLEN-1:0]  divisorReg;
  logic             remOpReg;
  logic             negQuoReg;
  logic             negRemReg;

  // Decode of the incoming instruction, used only in the accept cycle.
  divOp_t          opIn;
  logic            inSigned, inRem, signA, signB;
  logic [XLEN-1:0] magA, magB, specialRes;
  logic            divByZero, overflow, isSpecial, accept, lastStep;

  assign opIn     = divOp_t'(EX_DivOp);
  assign inSigned = (opIn == DIV_OP_DIV) || (opIn == DIV_OP_REM);
  assign inRem    = (opIn == DIV_OP_REM) || (opIn == DIV_OP_REMU);
  assign signA    = inSigned & EX_Rs1Data[XLEN-1];
  assign signB    = inSigned & EX_Rs2Data[XLEN-1];
  assign magA     = signA ? -EX_Rs1Data : EX_Rs1Data;
  assign magB     = signB ? -EX_Rs2Data : EX_Rs2Data;

  assign divByZero  = (EX_Rs2Data == '0);
  assign overflow   = inSigned && (EX_Rs1Data == MIN_INT) && (EX_Rs2Data == '1);
  assign isSpecial  = divByZero | overflow;
  assign specialRes = divByZero ? (inRem ? EX_Rs1Data : '1)
                                : (inRem ? '0 : MIN_INT);

  assign accept   = (state == DIV_IDLE) & EX_DivValid & ~EX_Flush;
  assign lastStep = (cnt == LAST_STEP);

  // Datapath step and sign fix-up applied to the final step's output.
  logic [XLEN:0]   stepRem;
  logic [XLEN-1:0] stepQuo, fixedQuo, fixedRem;

  div_step #(.XLEN(XLEN)) uStep (
    .rem     (remReg),
    .quo     (quoReg),
    .divisor (divisorReg),
    .remNext (stepRem),
    .quoNext (stepQuo)
  );

  assign fixedQuo = negQuoReg ? -stepQuo : stepQuo;
  assign fixedRem = negRemReg ? -stepRem[XLEN-1:0] : stepRem[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (EX_Flush) begin
      stateNext = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (EX_DivValid) stateNext = isSpecial ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (lastStep) stateNext = DIV_DONE;
        DIV_DONE: if (!EX_Hold) stateNext = DIV_IDLE;
        default:  stateNext = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      remOpReg   <= 1'b0;
      negQuoReg  <= 1'b0;
      negRemReg  <= 1'b0;
      Div_Result <= '0;
    end else if (accept) begin
      cnt        <= '0;
      remReg     <= '0;
      quoReg     <= magA;
      divisorReg <= magB;
      remOpReg   <= inRem;
      negQuoReg  <= signA ^ signB;
      negRemReg  <= signA;
      if (isSpecial) begin
        Div_Result <= specialRes;
      end
    end else if ((state == DIV_BUSY) && !EX_Flush) begin
      remReg <= stepRem;
      quoReg <= stepQuo;
      cnt    <= lastStep ? '0 : cnt + CNT_W'(1);
      if (lastStep) begin
        Div_Result <= remOpReg ? fixedRem : fixedQuo;
      end
    end
  end

  assign Div_Done    = (state == DIV_DONE);
  assign EX_StallReq = EX_DivValid & ~EX_Flush & (state != DIV_DONE);

endmodule

// File: tb/tb_ex_divider.sv
// tb/tb_ex_divider.sv - self-checking bench for ex_divider
module tb_ex_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_DivValid;
  logic [1:0]  EX_DivOp;
  logic [31:0] EX_Rs1Data;
  logic [31:0] EX_Rs2Data;
  logic        EX_Flush;
  logic        EX_Hold;
  logic        EX_StallReq;
  logic        Div_Done;
  logic [31:0] Div_Result;

  int checks = 0;
  int errors = 0;

  ex_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .EX_DivValid (EX_DivValid),
    .EX_DivOp    (EX_DivOp),
    .EX_Rs1Data  (EX_Rs1Data),
    .EX_Rs2Data  (EX_Rs2Data),
    .EX_Flush    (EX_Flush),
    .EX_Hold     (EX_Hold),
    .EX_StallReq (EX_StallReq),
    .Div_Done    (Div_Done),
    .Div_Result  (Div_Result)
  );

  always #5 clk = ~clk;

  function automatic logic isSpecialCase(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M semantics written with ordinary arithmetic.
  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic isRem;
    logic isSigned;
    isRem    = op[1];
    isSigned = !op[0];
    if (b == 0) return isRem ? a : 32'hFFFF_FFFF;
    if (isSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isRem ? 32'h0 : 32'h8000_0000;
    if (isSigned) return isRem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return isRem ? a % b : a / b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at negedge+1 with the unit idle; returns at negedge+1 with it idle.
  task automatic runDiv(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int stalls = 0;
    int cycles = 0;
    int expStalls;
    expStalls   = isSpecialCase(op, a, b) ? 1 : 33;
    EX_DivOp    = op;
    EX_Rs1Data  = a;
    EX_Rs2Data  = b;
    EX_DivValid = 1'b1;
    #1;
    while (Div_Done !== 1'b1 && cycles < 100) begin
      if (EX_StallReq) stalls++;
      cycles++;
      @(negedge clk); #1;
    end
    check($sformatf("%s_stalls", tag), 32'(stalls), 32'(expStalls));
    check($sformatf("%s_result", tag), Div_Result, refModel(op, a, b));
    check($sformatf("%s_stall_in_done", tag), {31'b0, EX_StallReq}, 32'h0);
    EX_DivValid = 1'b0;
    @(negedge clk); #1;
    check($sformatf("%s_done_clear", tag), {31'b0, Div_Done}, 32'h0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          stalls;
    int          cycles;

    rst_n       = 1'b0;
    EX_DivValid = 1'b0;
    EX_DivOp    = 2'b00;
    EX_Rs1Data  = '0;
    EX_Rs2Data  = '0;
    EX_Flush    = 1'b0;
    EX_Hold     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", {31'b0, EX_StallReq}, 32'h0);
    check("reset_done", {31'b0, Div_Done}, 32'h0);
    check("reset_result", Div_Result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed cases from the plan.
    runDiv("divu_100_7", 2'b01, 32'd100, 32'd7);
    runDiv("remu_100_7", 2'b11, 32'd100, 32'd7);
    runDiv("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    runDiv("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    runDiv("div_5_0", 2'b00, 32'd5, 32'd0);
    runDiv("rem_5_0", 2'b10, 32'd5, 32'd0);
    runDiv("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    runDiv("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    runDiv("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE);
    runDiv("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);

    // Flush at BUSY cycle 10, then a fresh divide.
    EX_DivOp    = 2'b01;
    EX_Rs1Data  = 32'd1000;
    EX_Rs2Data  = 32'd7;
    EX_DivValid = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    EX_Flush = 1'b1;
    #1;
    check("flush_stall_low", {31'b0, EX_StallReq}, 32'h0);
    @(negedge clk); #1;
    EX_Flush    = 1'b0;
    EX_DivValid = 1'b0;
    check("flush_no_done", {31'b0, Div_Done}, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("flush_still_no_done", {31'b0, Div_Done}, 32'h0);
    runDiv("after_flush_9_3", 2'b01, 32'd9, 32'd3);

    // Hold during BUSY is ignored; hold in DONE keeps the result for 5 cycles.
    EX_DivOp    = 2'b01;
    EX_Rs1Data  = 32'd100;
    EX_Rs2Data  = 32'd7;
    EX_DivValid = 1'b1;
    stalls = 0;
    cycles = 0;
    #1;
    while (Div_Done !== 1'b1 && cycles < 100) begin
      EX_Hold = (cycles >= 5 && cycles <= 8);
      if (EX_StallReq) stalls++;
      cycles++;
      @(negedge clk); #1;
    end
    EX_Hold = 1'b0;
    check("hold_busy_stalls", 32'(stalls), 32'd33);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_done_%0d", k), {31'b0, Div_Done}, 32'h1);
      check($sformatf("hold_result_%0d", k), Div_Result, 32'd14);
      check($sformatf("hold_stall_%0d", k), {31'b0, EX_StallReq}, 32'h0);
      EX_Hold = (k < 4);
      if (k == 4) EX_DivValid = 1'b0;
      @(negedge clk); #1;
    end
    check("hold_release_idle", {31'b0, Div_Done}, 32'h0);

    // Asynchronous reset while BUSY.
    EX_DivOp    = 2'b01;
    EX_Rs1Data  = 32'hFFFF_FFFF;
    EX_Rs2Data  = 32'd3;
    EX_DivValid = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    rst_n       = 1'b0;
    EX_DivValid = 1'b0;
    #1;
    check("rst_busy_done", {31'b0, Div_Done}, 32'h0);
    check("rst_busy_result", Div_Result, 32'h0);
    check("rst_busy_stall", {31'b0, EX_StallReq}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    runDiv("after_reset", 2'b01, 32'hFFFF_FFFF, 32'd3);

    // Randomized operations with a bias toward the special cases.
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      runDiv($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
